// File: rtl/senone_sram_sender.sv
// senone_sram_sender: reads N_SENONES big-endian 16-bit words from a byte-wide
// asynchronous SRAM and hands each one to a UART transmitter with a one-cycle
// strobe. It pulses send_done when the last word has been accepted.
module senone_sram_sender #(
  parameter int          N_SENONES   = 5,
  parameter logic [20:0] BASE_ADDR   = 21'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_send,
  input  logic        new_vector_incoming,
  input  logic        uart_ready,
  output logic        start_tx,
  output logic [15:0] tx_value,
  output logic        send_done,
  output logic [20:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we
);

  localparam int IDX_W  = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_HI,
    S_READ_LO,
    S_SEND,
    S_BUSY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [7:0]         hi_q, hi_d;
  logic [7:0]         lo_q, lo_d;
  logic               seen_low_q, seen_low_d;
  logic [15:0]        tx_value_q, tx_value_d;
  logic               start_tx_q, start_tx_d;
  logic               send_done_q, send_done_d;
  logic [20:0]        sram_addr_q, sram_addr_d;
  logic               sram_sel_q, sram_sel_d;
  logic               last_wait;
  logic               last_word;

  // The data bus is only ever sampled; nothing in this block drives it.
  assign sram_we   = 1'b1;
  assign sram_ce   = ~sram_sel_q;
  assign sram_oe   = ~sram_sel_q;
  assign sram_addr = sram_addr_q;
  assign start_tx  = start_tx_q;
  assign tx_value  = tx_value_q;
  assign send_done = send_done_q;

  // Next-state logic: byte reads, UART handshake, abort handling and SRAM pin values.
  always_comb begin
    // NOTE: every variable gets a default before the case statement so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    seen_low_d  = seen_low_q;
    tx_value_d  = tx_value_q;
    start_tx_d  = 1'b0;
    send_done_d = 1'b0;
    last_wait   = (wait_q == WAIT_W'(WAIT_CYCLES - 1));
    last_word   = (idx_q == IDX_W'(N_SENONES - 1));

    case (state_q)
      S_IDLE: begin
        if (start_send && !new_vector_incoming) begin
          idx_d   = '0;
          wait_d  = '0;
          state_d = S_READ_HI;
        end
      end
      S_READ_HI: begin
        if (last_wait) begin
          hi_d    = sram_data;
          wait_d  = '0;
          state_d = S_READ_LO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_READ_LO: begin
        if (last_wait) begin
          lo_d    = sram_data;
          wait_d  = '0;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_SEND: begin
        if (uart_ready) begin
          tx_value_d = {hi_q, lo_q};
          start_tx_d = 1'b1;
          seen_low_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // Only a low-then-high ready sequence ends the word, so a ready that
        // is still high from before the strobe cannot trigger a resend.
        if (!uart_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            wait_d  = '0;
            state_d = S_READ_HI;
          end
        end
      end
      S_DONE: begin
        send_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything outside IDLE; an already-issued strobe stays.
    if (state_q != S_IDLE && new_vector_incoming) begin
      state_d     = S_IDLE;
      start_tx_d  = 1'b0;
      send_done_d = 1'b0;
      tx_value_d  = tx_value_q;
    end

    // SRAM pins are registered from the next state so they line up with it.
    sram_sel_d  = (state_d == S_READ_HI) || (state_d == S_READ_LO);
    sram_addr_d = sram_sel_d
                ? BASE_ADDR + (21'(idx_d) << 1) + {20'd0, (state_d == S_READ_LO)}
                : sram_addr_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      seen_low_q  <= 1'b0;
      tx_value_q  <= 16'h0000;
      start_tx_q  <= 1'b0;
      send_done_q <= 1'b0;
      sram_addr_q <= 21'h0;
      sram_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      seen_low_q  <= seen_low_d;
      tx_value_q  <= tx_value_d;
      start_tx_q  <= start_tx_d;
      send_done_q <= send_done_d;
      sram_addr_q <= sram_addr_d;
      sram_sel_q  <= sram_sel_d;
    end
  end

endmodule

// File: tb/tb_senone_sram_sender.sv
// Testbench for senone_sram_sender: two instances (default parameters and a
// small one at BASE_ADDR 0x1000), SRAM and UART models, and a scoreboard whose
// expected words and address windows come straight from memory contents.
`timescale 1ns/1ps
module tb_senone_sram_sender;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Instance A signals (defaults: N=5, base 0, wait 2)
  logic        start_send_a, new_vec_a, uart_ready_a, ready_m_a, block_a;
  logic        start_tx_a, send_done_a, sram_ce_a, sram_oe_a, sram_we_a;
  logic [15:0] tx_value_a;
  logic [20:0] sram_addr_a;
  wire  [7:0]  sram_data_a;
  logic [7:0]  mem_a [8192];
  int          dip_a;

  // Instance B signals (N=1, base 0x1000, wait 4)
  logic        start_send_b, new_vec_b, uart_ready_b, ready_m_b;
  logic        start_tx_b, send_done_b, sram_ce_b, sram_oe_b, sram_we_b;
  logic [15:0] tx_value_b;
  logic [20:0] sram_addr_b;
  wire  [7:0]  sram_data_b;
  logic [7:0]  mem_b [8192];
  int          dip_b;

  // Scoreboard state
  logic [15:0] wq_a[$], wq_b[$];
  logic [20:0] aq_a[$], aq_b[$];
  int          done_exp[2];
  int          lat_t0[2];
  bit          lat_armed[2];
  int          lat_exp[2];
  logic [15:0] last_word[2];

  senone_sram_sender #(.N_SENONES(5), .BASE_ADDR(21'h0), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .start_send(start_send_a),
    .new_vector_incoming(new_vec_a), .uart_ready(uart_ready_a),
    .start_tx(start_tx_a), .tx_value(tx_value_a), .send_done(send_done_a),
    .sram_addr(sram_addr_a), .sram_data(sram_data_a),
    .sram_ce(sram_ce_a), .sram_oe(sram_oe_a), .sram_we(sram_we_a));

  senone_sram_sender #(.N_SENONES(1), .BASE_ADDR(21'h1000), .WAIT_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .start_send(start_send_b),
    .new_vector_incoming(new_vec_b), .uart_ready(uart_ready_b),
    .start_tx(start_tx_b), .tx_value(tx_value_b), .send_done(send_done_b),
    .sram_addr(sram_addr_b), .sram_data(sram_data_b),
    .sram_ce(sram_ce_b), .sram_oe(sram_oe_b), .sram_we(sram_we_b));

  // Asynchronous SRAM models: drive the bus only while selected and read-enabled.
  assign sram_data_a = (!sram_ce_a && !sram_oe_a) ? mem_a[sram_addr_a[12:0]] : 8'hzz;
  assign sram_data_b = (!sram_ce_b && !sram_oe_b) ? mem_b[sram_addr_b[12:0]] : 8'hzz;
  assign uart_ready_a = ready_m_a & ~block_a;
  assign uart_ready_b = ready_m_b;

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // UART models: drop ready in the strobe cycle and raise it dip cycles later.
  initial begin
    ready_m_a = 1'b1;
    forever begin
      @(negedge clk);
      if (start_tx_a === 1'b1) begin
        check("a_ready_at_tx", uart_ready_a, 1);
        ready_m_a = 1'b0;
        repeat (dip_a) @(negedge clk);
        ready_m_a = 1'b1;
      end
    end
  end

  initial begin
    ready_m_b = 1'b1;
    forever begin
      @(negedge clk);
      if (start_tx_b === 1'b1) begin
        check("b_ready_at_tx", uart_ready_b, 1);
        ready_m_b = 1'b0;
        repeat (dip_b) @(negedge clk);
        ready_m_b = 1'b1;
      end
    end
  end

  // Monitor step for one instance: compares strobes, done pulses and reads.
  task automatic mon(input int inst, input logic stx, input logic [15:0] txv,
                     input logic dn, input logic [20:0] addr,
                     input logic ce, input logic oe, input logic we);
    logic [15:0] ew;
    logic [20:0] ea;
    int          n_w, n_a;
    n_w = (inst == 0) ? wq_a.size() : wq_b.size();
    n_a = (inst == 0) ? aq_a.size() : aq_b.size();
    if (stx) begin
      check($sformatf("tx_expected%0d", inst), n_w != 0, 1);
      if (n_w != 0) begin
        if (inst == 0) ew = wq_a.pop_front(); else ew = wq_b.pop_front();
        check($sformatf("tx_value%0d", inst), txv, ew);
        last_word[inst] = ew;
      end
      if (lat_armed[inst]) begin
        lat_armed[inst] = 1'b0;
        check($sformatf("latency%0d", inst), cyc - lat_t0[inst], lat_exp[inst]);
      end
    end
    if (dn) begin
      check($sformatf("done_expected%0d", inst), done_exp[inst] > 0, 1);
      check($sformatf("done_no_tx%0d", inst), stx, 0);
      check($sformatf("done_after_words%0d", inst), n_w, 0);
      if (done_exp[inst] > 0) done_exp[inst]--;
    end
    if (!ce) begin
      check($sformatf("oe_with_ce%0d", inst), oe, 0);
      check($sformatf("we_high%0d", inst), we, 1);
      check($sformatf("read_expected%0d", inst), n_a != 0, 1);
      if (n_a != 0) begin
        if (inst == 0) ea = aq_a.pop_front(); else ea = aq_b.pop_front();
        check($sformatf("sram_addr%0d", inst), addr, ea);
      end
    end else begin
      check($sformatf("oe_idle%0d", inst), oe, 1);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, start_tx_a, tx_value_a, send_done_a, sram_addr_a, sram_ce_a, sram_oe_a, sram_we_a);
      mon(1, start_tx_b, tx_value_b, send_done_b, sram_addr_b, sram_ce_b, sram_oe_b, sram_we_b);
    end
  end

  // Reference model: expected words and per-cycle addresses from memory contents.
  task automatic request(input int inst, input bit arm);
    int          n, w, base, b;
    logic [15:0] word;
    if (inst == 0) begin n = 5; w = 2; base = 0; end
    else begin n = 1; w = 4; base = 'h1000; end
    for (int i = 0; i < n; i++) begin
      b = base + 2 * i;
      if (inst == 0) begin
        word = {mem_a[b], mem_a[b + 1]};
        wq_a.push_back(word);
      end else begin
        word = {mem_b[b], mem_b[b + 1]};
        wq_b.push_back(word);
      end
    end
    for (int j = 0; j < 2 * n; j++) begin
      for (int k = 0; k < w; k++) begin
        if (inst == 0) aq_a.push_back(21'(base + j));
        else aq_b.push_back(21'(base + j));
      end
    end
    done_exp[inst]++;
    if (arm) begin
      lat_t0[inst]    = cyc;
      lat_armed[inst] = 1'b1;
    end
    if (inst == 0) start_send_a = 1'b1; else start_send_b = 1'b1;
    tick();
    start_send_a = 1'b0;
    start_send_b = 1'b0;
  endtask

  function automatic bit idle_ok(input int inst);
    if (inst == 0) return (wq_a.size() == 0) && (aq_a.size() == 0) && (done_exp[0] == 0);
    return (wq_b.size() == 0) && (aq_b.size() == 0) && (done_exp[1] == 0);
  endfunction

  task automatic wait_done(input int inst, input int budget);
    int i;
    i = 0;
    while (i < budget && !idle_ok(inst)) begin
      tick();
      i++;
    end
    check($sformatf("complete%0d", inst), idle_ok(inst), 1);
    check($sformatf("tx_hold%0d", inst), (inst == 0) ? tx_value_a : tx_value_b, last_word[inst]);
  endtask

  task automatic check_reset_a();
    check("rst_start_tx", start_tx_a, 0);
    check("rst_send_done", send_done_a, 0);
    check("rst_tx_value", tx_value_a, 0);
    check("rst_sram_addr", sram_addr_a, 0);
    check("rst_ce_oe_we", {sram_ce_a, sram_oe_a, sram_we_a}, 3'b111);
  endtask

  initial begin
    logic [7:0] basic [10];
    bit         found;
    int         i;
    basic = '{8'h80, 8'h08, 8'h00, 8'h01, 8'h7F, 8'hFF, 8'hFF, 8'hFE, 8'h12, 8'h34};
    foreach (mem_a[j]) mem_a[j] = 8'(j * 7 + 3);
    foreach (mem_b[j]) mem_b[j] = 8'(j * 5 + 1);
    for (int j = 0; j < 10; j++) mem_a[j] = basic[j];
    lat_exp[0] = 6;
    lat_exp[1] = 10;
    start_send_a = 0; new_vec_a = 0; block_a = 0; dip_a = 100;
    start_send_b = 0; new_vec_b = 0; dip_b = 3;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_a();
    check("b_rst_ce_oe_we", {sram_ce_b, sram_oe_b, sram_we_b}, 3'b111);
    check("b_rst_tx_value", tx_value_b, 0);
    reset = 1'b0;
    tick();

    // Basic vector with a slow UART
    request(0, 1);
    wait_done(0, 2000);

    // Latency with a short busy dip
    dip_a = 2;
    request(0, 1);
    wait_done(0, 500);

    // Second request much later, with a stray start_send mid-transfer
    repeat (25000) tick();
    request(0, 1);
    repeat (20) tick();
    start_send_a = 1'b1;
    tick();
    start_send_a = 1'b0;
    wait_done(0, 500);

    // Randomized contents and UART busy times
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 10; j++) mem_a[j] = 8'($urandom_range(0, 255));
      dip_a = int'($urandom_range(1, 6));
      request(0, 1);
      wait_done(0, 1000);
    end

    // Abort during READ_LO of word 2
    request(0, 1);
    found = 1'b0;
    i = 0;
    while (i < 300 && !found) begin
      tick();
      if (!sram_ce_a && sram_addr_a == 21'd5) found = 1'b1;
      i++;
    end
    check("abort_reached_word2_lo", found, 1);
    new_vec_a = 1'b1;
    wq_a.delete();
    aq_a.delete();
    done_exp[0]--;
    tick();
    new_vec_a = 1'b0;
    check("abort_ce_oe", {sram_ce_a, sram_oe_a}, 2'b11);
    check("abort_start_tx", start_tx_a, 0);
    repeat (60) tick();

    // start_send with new_vector_incoming in IDLE stays idle
    start_send_a = 1'b1;
    new_vec_a    = 1'b1;
    tick();
    start_send_a = 1'b0;
    new_vec_a    = 1'b0;
    repeat (4) tick();
    check("both_high_stays_idle", sram_ce_a, 1);

    // Reset while parked in SEND
    block_a = 1'b1;
    request(0, 0);
    found = 1'b0;
    i = 0;
    while (i < 50 && !found) begin
      tick();
      if (!sram_ce_a) found = 1'b1;
      i++;
    end
    check("rst_reached_read", found, 1);
    found = 1'b0;
    i = 0;
    while (i < 50 && !found) begin
      tick();
      if (sram_ce_a) found = 1'b1;
      i++;
    end
    check("rst_reached_send", found, 1);
    repeat (3) tick();
    reset = 1'b1;
    wq_a.delete();
    aq_a.delete();
    done_exp[0]--;
    tick();
    check_reset_a();
    reset   = 1'b0;
    block_a = 1'b0;
    tick();
    for (int j = 0; j < 10; j++) mem_a[j] = 8'($urandom_range(0, 255));
    request(0, 1);
    wait_done(0, 1000);

    // Second parameter set
    mem_b['h1000] = 8'($urandom_range(0, 255));
    mem_b['h1001] = 8'($urandom_range(0, 255));
    request(1, 1);
    wait_done(1, 500);

    repeat (10) tick();
    check("a_no_leftover", wq_a.size() + aq_a.size() + done_exp[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
